// File: rtl/mem_write_checker.sv
// Watches the MIPS data-memory write port and latches a sticky verdict.
// Counts stores and run cycles; all outputs are registered.
module mem_write_checker #(
    parameter logic [31:0] PASS_ADR    = 32'd32,
    parameter logic [31:0] FAIL_ADR    = 32'd16,
    parameter logic [31:0] EXPECT_DATA = 32'd15,
    parameter logic [31:0] FORBID_ADR0 = 32'd30,
    parameter logic [31:0] FORBID_ADR1 = 32'd20,
    parameter int          SETTLE      = 1,
    parameter int          TIMEOUT     = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [2:0]  fail_code,
    output logic [15:0] store_count,
    output logic [15:0] cycle_count,
    output logic [31:0] last_adr,
    output logic [31:0] last_data
);

    typedef enum logic [1:0] {
        S_SETTLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_e;

    localparam logic [3:0]  SETTLE_M1  = 4'(SETTLE - 1);
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_FSTORE  = 3'd1;
    localparam logic [2:0] CODE_FORBID  = 3'd2;
    localparam logic [2:0] CODE_TIMEOUT = 3'd3;

    state_e      state_q;
    logic [3:0]  settle_q;
    logic        done_q;
    logic        pass_q;
    logic        fail_q;
    logic [2:0]  code_q;
    logic [15:0] store_q;
    logic [15:0] cycle_q;
    logic [31:0] last_adr_q;
    logic [31:0] last_data_q;

    logic        wr_en;
    logic        rd_en;
    logic        fail_hit;
    logic        pass_hit;
    logic        forbid_hit;
    logic        timeout_hit;
    logic [15:0] store_d;
    logic [15:0] cycle_d;

    // Rule matching; case equality makes X/Z inputs count as mismatches.
    always_comb begin
        wr_en       = (memwrite === 1'b1);
        rd_en       = (memwrite === 1'b0);
        fail_hit    = wr_en
                   && (dataadr === FAIL_ADR)
                   && (writedata === EXPECT_DATA);
        pass_hit    = wr_en
                   && (dataadr === PASS_ADR)
                   && (writedata === EXPECT_DATA);
        forbid_hit  = rd_en
                   && ((dataadr === FORBID_ADR0)
                    || (dataadr === FORBID_ADR1));
        timeout_hit = (cycle_q == TIMEOUT_M1);
        store_d     = (store_q == 16'hFFFF) ? store_q : store_q + 16'd1;
        cycle_d     = (cycle_q == 16'hFFFF) ? cycle_q : cycle_q + 16'd1;
    end

    // Checker FSM with registered verdict, counters and last-store capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_SETTLE;
            settle_q    <= 4'd0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            code_q      <= CODE_NONE;
            store_q     <= 16'd0;
            cycle_q     <= 16'd0;
            last_adr_q  <= 32'd0;
            last_data_q <= 32'd0;
        end else begin
            unique case (state_q)
                S_SETTLE: begin
                    if (settle_q == SETTLE_M1) begin
                        state_q <= S_RUN;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                S_RUN: begin
                    cycle_q <= cycle_d;
                    if (wr_en) begin
                        last_adr_q  <= dataadr;
                        last_data_q <= writedata;
                    end
                    if (fail_hit) begin
                        state_q <= S_FAIL;
                        done_q  <= 1'b1;
                        fail_q  <= 1'b1;
                        code_q  <= CODE_FSTORE;
                    end else if (pass_hit) begin
                        state_q <= S_PASS;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b1;
                    end else if (wr_en) begin
                        store_q <= store_d;
                    end else if (forbid_hit) begin
                        state_q <= S_FAIL;
                        done_q  <= 1'b1;
                        fail_q  <= 1'b1;
                        code_q  <= CODE_FORBID;
                    end else if (timeout_hit) begin
                        state_q <= S_FAIL;
                        done_q  <= 1'b1;
                        fail_q  <= 1'b1;
                        code_q  <= CODE_TIMEOUT;
                    end
                end
                S_PASS: begin
                    state_q <= S_PASS;
                end
                S_FAIL: begin
                    state_q <= S_FAIL;
                end
                default: begin
                    state_q <= S_SETTLE;
                end
            endcase
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_code   = code_q;
    assign store_count = store_q;
    assign cycle_count = cycle_q;
    assign last_adr    = last_adr_q;
    assign last_data   = last_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: vector table on a default
// instance plus timeout sequences on an instance with TIMEOUT=8.
module tb_mem_write_checker;

    typedef struct packed {
        logic        done;
        logic        pass;
        logic        fail;
        logic [2:0]  code;
        logic [15:0] sc;
        logic [15:0] cc;
        logic [31:0] la;
        logic [31:0] ld;
    } obs_t;

    typedef struct {
        logic        rst;
        logic        mw;
        logic [31:0] adr;
        logic [31:0] dat;
        obs_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = 32'd0;
    logic [31:0] writedata = 32'd0;

    logic        done_a, pass_a, fail_a;
    logic [2:0]  code_a;
    logic [15:0] sc_a, cc_a;
    logic [31:0] la_a, ld_a;

    logic        done_b, pass_b, fail_b;
    logic [2:0]  code_b;
    logic [15:0] sc_b, cc_b;
    logic [31:0] la_b, ld_b;

    obs_t obs_a;
    obs_t obs_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_write_checker u_dut (
        .clk(clk),
        .reset(reset),
        .memwrite(memwrite),
        .dataadr(dataadr),
        .writedata(writedata),
        .done(done_a),
        .pass(pass_a),
        .fail(fail_a),
        .fail_code(code_a),
        .store_count(sc_a),
        .cycle_count(cc_a),
        .last_adr(la_a),
        .last_data(ld_a)
    );

    mem_write_checker #(.TIMEOUT(8)) u_to (
        .clk(clk),
        .reset(reset),
        .memwrite(memwrite),
        .dataadr(dataadr),
        .writedata(writedata),
        .done(done_b),
        .pass(pass_b),
        .fail(fail_b),
        .fail_code(code_b),
        .store_count(sc_b),
        .cycle_count(cc_b),
        .last_adr(la_b),
        .last_data(ld_b)
    );

    assign obs_a = {done_a, pass_a, fail_a, code_a, sc_a, cc_a, la_a, ld_a};
    assign obs_b = {done_b, pass_b, fail_b, code_b, sc_b, cc_b, la_b, ld_b};

    function automatic obs_t o(input int d, input int p, input int f,
                               input int c, input int sc, input int cc,
                               input int la, input int ld);
        obs_t r;
        r.done = d[0];
        r.pass = p[0];
        r.fail = f[0];
        r.code = c[2:0];
        r.sc   = sc[15:0];
        r.cc   = cc[15:0];
        r.la   = la;
        r.ld   = ld;
        return r;
    endfunction

    function automatic vec_t v(input int r, input int m, input int adr,
                               input int dat, input obs_t e);
        vec_t x;
        x.rst = r[0];
        x.mw  = m[0];
        x.adr = adr;
        x.dat = dat;
        x.exp = e;
        return x;
    endfunction

    task automatic chk(input string nm, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got d=%0d p=%0d f=%0d code=%0d sc=%0d cc=%0d la=%0d ld=%0d, want d=%0d p=%0d f=%0d code=%0d sc=%0d cc=%0d la=%0d ld=%0d",
                     nm, act.done, act.pass, act.fail, act.code, act.sc,
                     act.cc, act.la, act.ld, exp.done, exp.pass, exp.fail,
                     exp.code, exp.sc, exp.cc, exp.la, exp.ld);
        end
    endtask

    task automatic step(input logic r, input logic m,
                        input logic [31:0] a, input logic [31:0] d);
        reset     = r;
        memwrite  = m;
        dataadr   = a;
        writedata = d;
        @(posedge clk);
        #1;
    endtask

    vec_t vt[25];

    initial begin
        vt[0]  = v(0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));
        vt[1]  = v(0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));
        vt[2]  = v(0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));
        vt[3]  = v(1, 1, 16, 15, o(0, 0, 0, 0, 0, 0, 0, 0));
        vt[4]  = v(1, 1, 80, 7, o(0, 0, 0, 0, 1, 1, 80, 7));
        vt[5]  = v(1, 1, 32, 15, o(1, 1, 0, 0, 1, 2, 32, 15));
        vt[6]  = v(1, 1, 16, 15, o(1, 1, 0, 0, 1, 2, 32, 15));
        vt[7]  = v(0, 1, 32, 15, o(0, 0, 0, 0, 0, 0, 0, 0));
        vt[8]  = v(1, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));
        vt[9]  = v(1, 1, 16, 15, o(1, 0, 1, 1, 0, 1, 16, 15));
        vt[10] = v(1, 1, 32, 15, o(1, 0, 1, 1, 0, 1, 16, 15));
        vt[11] = v(1, 0, 30, 0, o(1, 0, 1, 1, 0, 1, 16, 15));
        vt[12] = v(0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));
        vt[13] = v(1, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));
        vt[14] = v(1, 1, 20, 7, o(0, 0, 0, 0, 1, 1, 20, 7));
        vt[15] = v(1, 0, 20, 99, o(1, 0, 1, 2, 1, 2, 20, 7));
        vt[16] = v(0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));
        vt[17] = v(1, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));
        vt[18] = v(1, 0, 30, 0, o(1, 0, 1, 2, 0, 1, 0, 0));
        vt[19] = v(0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));
        vt[20] = v(1, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));
        vt[21] = v(1, 1, 32, 14, o(0, 0, 0, 0, 1, 1, 32, 14));
        vt[22] = v(1, 1, 16, 16, o(0, 0, 0, 0, 2, 2, 16, 16));
        vt[23] = v(1, 0, 4, 0, o(0, 0, 0, 0, 2, 3, 16, 16));
        vt[24] = v(1, 1, 32, 15, o(1, 1, 0, 0, 2, 4, 32, 15));

        @(posedge clk);
        #1;

        for (int i = 0; i < 25; i++) begin
            step(vt[i].rst, vt[i].mw, vt[i].adr, vt[i].dat);
            chk($sformatf("vec%0d", i), obs_a, vt[i].exp);
        end

        // Timeout: 8 idle run cycles on the TIMEOUT=8 instance.
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("to_settle", obs_b, o(0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 0, 0);
        end
        chk("to_before", obs_b, o(0, 0, 0, 0, 0, 7, 0, 0));
        step(1, 0, 0, 0);
        chk("to_fire", obs_b, o(1, 0, 1, 3, 0, 8, 0, 0));
        step(1, 1, 32, 15);
        chk("to_frozen", obs_b, o(1, 0, 1, 3, 0, 8, 0, 0));

        // Pass store on the timeout cycle wins over timeout.
        step(0, 0, 0, 0);
        chk("to_reset", obs_b, o(0, 0, 0, 0, 0, 0, 0, 0));
        step(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 0, 0);
        end
        step(1, 1, 32, 15);
        chk("to_pass_wins", obs_b, o(1, 1, 0, 0, 0, 8, 32, 15));
        chk("dflt_pass_8", obs_a, o(1, 1, 0, 0, 0, 8, 32, 15));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable self-check unit that sits directly downstream of the MIPS `top` and watches its data-memory write port (`memwrite`, `dataadr`, `writedata`). It applies the team's standard pass/fail rules for the bring-up program every cycle, counts stores and cycles, and latches a sticky verdict. Benches and FPGA builds can then read pass/fail from registered outputs instead of open-coded `$display`/`$stop` logic.

## Interface
- `PASS_ADR`, default 32: store address that signals success when paired with `EXPECT_DATA`.
- `FAIL_ADR`, default 16: store address that signals failure when paired with `EXPECT_DATA`.
- `EXPECT_DATA`, default 15: data value that qualifies the pass and fail stores.
- `FORBID_ADR0`, default 30: address that must never appear on `dataadr` while `memwrite`=0.
- `FORBID_ADR1`, default 20: second forbidden address, same rule as `FORBID_ADR0`.
- `SETTLE`, default 1: cycles after reset release during which all inputs are ignored (1..15).
- `TIMEOUT`, default 1000: cycle budget in `RUN` before a timeout failure (2..65535).
- `clk` input 1: sole clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low reset (0 = reset).
- `memwrite` input 1: data-memory write enable from `top`.
- `dataadr` input 32: data-memory address from `top`.
- `writedata` input 32: store data from `top`.
- `done` output 1: verdict reached; sticky.
- `pass` output 1: verdict is success; sticky.
- `fail` output 1: verdict is failure; sticky.
- `fail_code` output 3: 0 none, 1 fail-store, 2 forbidden address, 3 timeout.
- `store_count` output 16: non-deciding stores accepted in `RUN`; saturates at 16'hFFFF.
- `cycle_count` output 16: cycles spent in `RUN`; saturates at 16'hFFFF.
- `last_adr` output 32: `dataadr` of the most recent sampled store.
- `last_data` output 32: `writedata` of the most recent sampled store.

## Operation
- FSM states: `SETTLE`, `RUN`, `PASS`, `FAIL`.
- Reset (`reset`=0 at a rising edge):
  - state = `SETTLE`, settle counter = 0.
  - All outputs 0.
- `SETTLE`: inputs ignored; the settle counter increments each cycle. When the counter reaches `SETTLE`-1, the FSM moves to `RUN`.
- `RUN` evaluates each cycle in strict priority order; the first match wins:
  1. `memwrite`=1 and `dataadr`==`FAIL_ADR` and `writedata`==`EXPECT_DATA`: go to `FAIL`, `fail_code`=1.
  2. `memwrite`=1 and `dataadr`==`PASS_ADR` and `writedata`==`EXPECT_DATA`: go to `PASS`.
  3. `memwrite`=1, any other address/data: `store_count`+1.
  4. `memwrite`=0 and `dataadr` equals `FORBID_ADR0` or `FORBID_ADR1`: go to `FAIL`, `fail_code`=2.
  5. `cycle_count`==`TIMEOUT`-1 and no rule above fired: go to `FAIL`, `fail_code`=3.
- Every `RUN` cycle, `cycle_count` increments, including the deciding cycle.
- On any sampled store with `memwrite`=1, including deciding stores, `last_adr` and `last_data` are updated.
- All address and data compares are full 32-bit equality; X/Z values on the inputs are treated as mismatch in the RTL.
- `PASS` and `FAIL` are terminal:
  - Inputs are ignored.
  - Counters and last-store registers freeze.
  - Only `reset` leaves these states.
- `done` = `pass` | `fail`. `pass` and `fail` are never both 1.

## Timing
- All outputs are registered.
- A deciding event present on the inputs before rising edge N is reflected on `done`/`pass`/`fail`/`fail_code` immediately after edge N. That is one-edge latency relative to the instruction's cycle in single-cycle `top`.
- First evaluated cycle is the `SETTLE`+1-th rising edge with `reset`=1.
- Reset asserted mid-run or after a verdict clears everything at the next rising edge, regardless of the other inputs on that edge.
- Timeout and a deciding store on the same edge: the store rule wins (priority 1/2 over 5).
- Saturation: `store_count` and `cycle_count` hold at 16'hFFFF.
- The timeout limit is ≤ 65535, so the timeout fires before `cycle_count` wraps.

## Test plan
- Reset held 3 cycles, then released. Cycle 1 has `memwrite`=1, `dataadr`=16, `writedata`=15 (`SETTLE`=1, so it is ignored). Cycle 2 has stores to 80/7, then 32/15 → `store_count`=1, `pass`=1, `fail_code`=0, `last_adr`=32, `last_data`=15 one edge after the 32/15 cycle.
- Store 16/15 in `RUN` → `fail`=1, `fail_code`=1, `done`=1. A later 32/15 store leaves `pass`=0 and counters frozen.
- `memwrite`=0 with `dataadr`=20 → `fail_code`=2. Repeat with 30 → `fail_code`=2. `memwrite`=1 with `dataadr`=20, data 7 → no verdict, `store_count`+1.
- `TIMEOUT`=8, no deciding activity → `fail_code`=3 exactly one edge after the 8th `RUN` cycle, `cycle_count`=8. Variant: 32/15 on that same cycle → `pass`=1.
- `reset` driven to 0 for one edge while in `PASS` → all outputs 0 next edge, FSM in `SETTLE`. A subsequent 32/15 after settle → `pass`=1 again.
- Stores 32/14 and 16/16 (data mismatch) → no verdict, `store_count`=2, `last_data`=16.
